// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the unified memory port.
// The arbiter takes the slave modport; the requesters and memory model take master.
interface unified_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_f3;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_f3;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_d;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_f3, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_read, mem_write, mem_wdata, mem_f3,
        output stall_if, stall_d, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_f3, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_read, mem_write, mem_wdata, mem_f3,
        input  stall_if, stall_d, busy
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and data requests onto one single-ported memory, one registered command
// per cycle, with a starvation guard for fetch and a tag pipeline routing read data back.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic                  clk,
    input logic                  rst,
    unified_mem_arbiter_if.slave bus
);
    typedef enum logic {StDpri, StIforce} state_e;

    localparam logic [3:0] StarveLim = 4'(STARVE_MAX - 1);

    state_e            state_q;
    logic [3:0]        starve_q;
    logic [ADDR_W-1:0] addr_q;
    logic              read_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        f3_q;
    logic [MEM_LAT:0]  tag_v_q;
    logic [MEM_LAT:0]  tag_d_q;

    logic if_win;
    logic d_win;
    logic if_denied;
    logic read_push;

    // No grant is issued while reset is held, since the command could not be registered.
    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (!rst) begin
            if (state_q == StIforce) begin
                if_win = bus.if_req;
                d_win  = bus.d_req & ~bus.if_req;
            end else begin
                d_win  = bus.d_req;
                if_win = bus.if_req & ~bus.d_req;
            end
        end
    end

    assign if_denied = bus.if_req & ~if_win;
    assign read_push = if_win | (d_win & ~bus.d_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StDpri;
            starve_q <= '0;
            addr_q   <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            f3_q     <= '0;
            tag_v_q  <= '0;
            tag_d_q  <= '0;
        end else begin
            unique case (state_q)
                StDpri: begin
                    if (if_denied && starve_q == StarveLim) state_q <= StIforce;
                end
                StIforce: begin
                    if (if_win || !bus.if_req) state_q <= StDpri;
                end
                default: state_q <= StDpri;
            endcase

            if (if_denied) begin
                if (starve_q != 4'hf) starve_q <= starve_q + 4'd1;
            end else begin
                starve_q <= '0;
            end

            read_q  <= read_push;
            write_q <= d_win & bus.d_we;
            if (if_win) begin
                addr_q <= bus.if_addr;
                f3_q   <= 3'b010;
            end else if (d_win) begin
                addr_q <= bus.d_addr;
                f3_q   <= bus.d_f3;
                if (bus.d_we) wdata_q <= bus.d_wdata;
            end

            // Entry i is valid in the i-th cycle after the command cycle; the head meets the data.
            for (int i = MEM_LAT; i > 0; i--) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_d_q[i] <= tag_d_q[i-1];
            end
            tag_v_q[0] <= read_push;
            tag_d_q[0] <= d_win;
        end
    end

    assign bus.if_gnt    = if_win;
    assign bus.d_gnt     = d_win;
    assign bus.stall_if  = if_denied;
    assign bus.stall_d   = bus.d_req & ~d_win;

    assign bus.mem_addr  = addr_q;
    assign bus.mem_read  = read_q;
    assign bus.mem_write = write_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_f3    = f3_q;

    assign bus.if_rvalid = tag_v_q[MEM_LAT] & ~tag_d_q[MEM_LAT];
    assign bus.d_rvalid  = tag_v_q[MEM_LAT] & tag_d_q[MEM_LAT];
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

    assign bus.busy      = read_q | write_q | (|tag_v_q);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Drives identical request streams into a MEM_LAT=0 and a MEM_LAT=1 arbiter, each with its own
// memory, and compares every cycle against a grant-order reference model.
module tb_unified_mem_arbiter;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned SM = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(0), .STARVE_MAX(SM)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SM)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    logic [31:0] mem0    [4096];
    logic [31:0] mem1    [4096];
    logic [31:0] ref_mem [4096];
    logic [31:0] rd1;

    assign bus0.mem_rdata = mem0[bus0.mem_addr];
    assign bus1.mem_rdata = rd1;

    always @(posedge clk) begin
        if (bus0.mem_write) mem0[bus0.mem_addr] <= bus0.mem_wdata;
        if (bus1.mem_write) mem1[bus1.mem_addr] <= bus1.mem_wdata;
        if (bus1.mem_read) rd1 <= mem1[bus1.mem_addr];
    end

    typedef struct {
        int unsigned due;
        logic        is_d;
        logic [31:0] data;
    } rd_t;

    rd_t q0[$];
    rd_t q1[$];

    logic        ec_read, ec_write;
    logic [11:0] ec_addr;
    logic [31:0] ec_wdata;
    logic [2:0]  ec_f3;
    int unsigned wait_n = 0;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [11:0] ia, input logic dr, input logic dw,
                         input logic [11:0] da, input logic [31:0] dwd, input logic [2:0] df);
        bus0.if_req = ir; bus0.if_addr = ia; bus0.d_req = dr; bus0.d_we = dw;
        bus0.d_addr = da; bus0.d_wdata = dwd; bus0.d_f3 = df;
        bus1.if_req = ir; bus1.if_addr = ia; bus1.d_req = dr; bus1.d_we = dw;
        bus1.d_addr = da; bus1.d_wdata = dwd; bus1.d_f3 = df;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        #1;
        check("rst_mem_read0", bus0.mem_read, 0);   check("rst_mem_read1", bus1.mem_read, 0);
        check("rst_mem_write0", bus0.mem_write, 0); check("rst_mem_write1", bus1.mem_write, 0);
        check("rst_mem_addr1", bus1.mem_addr, 0);   check("rst_mem_wdata1", bus1.mem_wdata, 0);
        check("rst_mem_f3_1", bus1.mem_f3, 0);      check("rst_busy0", bus0.busy, 0);
        check("rst_busy1", bus1.busy, 0);           check("rst_d_rvalid1", bus1.d_rvalid, 0);
        check("rst_if_rvalid1", bus1.if_rvalid, 0); check("rst_d_rvalid0", bus0.d_rvalid, 0);
        check("rst_if_gnt1", bus1.if_gnt, 0);       check("rst_d_gnt1", bus1.d_gnt, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        ec_read = 1'b0; ec_write = 1'b0; ec_addr = '0; ec_wdata = '0; ec_f3 = '0;
        wait_n = 0;
    endtask

    // One cycle: drive, check every output against the model, then advance the model.
    task automatic step(input logic ir, input logic [11:0] ia, input logic dr, input logic dw,
                        input logic [11:0] da, input logic [31:0] dwd, input logic [2:0] df,
                        output logic ig, output logic dg);
        logic v0, v1;
        rd_t  e;
        drive(ir, ia, dr, dw, da, dwd, df);
        #1;
        ig = ir && (!dr || wait_n >= SM);
        dg = dr && !ig;
        check("if_gnt0", bus0.if_gnt, ig);     check("if_gnt1", bus1.if_gnt, ig);
        check("d_gnt0", bus0.d_gnt, dg);       check("d_gnt1", bus1.d_gnt, dg);
        check("stall_if1", bus1.stall_if, ir && !ig);
        check("stall_d1", bus1.stall_d, dr && !dg);
        check("mem_read0", bus0.mem_read, ec_read);   check("mem_read1", bus1.mem_read, ec_read);
        check("mem_write0", bus0.mem_write, ec_write);
        check("mem_write1", bus1.mem_write, ec_write);
        check("mem_addr1", bus1.mem_addr, ec_addr);   check("mem_f3_1", bus1.mem_f3, ec_f3);
        if (ec_write) check("mem_wdata1", bus1.mem_wdata, ec_wdata);
        check("busy0", bus0.busy, ec_read || ec_write || q0.size() > 0);
        check("busy1", bus1.busy, ec_read || ec_write || q1.size() > 0);

        v0 = q0.size() > 0 && q0[0].due == cyc;
        v1 = q1.size() > 0 && q1[0].due == cyc;
        check("if_rvalid0", bus0.if_rvalid, v0 && !q0[0].is_d);
        check("d_rvalid0", bus0.d_rvalid, v0 && q0[0].is_d);
        check("if_rvalid1", bus1.if_rvalid, v1 && !q1[0].is_d);
        check("d_rvalid1", bus1.d_rvalid, v1 && q1[0].is_d);
        if (v0) begin
            e = q0.pop_front();
            if (e.is_d) check("d_rdata0", bus0.d_rdata, e.data);
            else        check("if_rdata0", bus0.if_rdata, e.data);
        end
        if (v1) begin
            e = q1.pop_front();
            if (e.is_d) check("d_rdata1", bus1.d_rdata, e.data);
            else        check("if_rdata1", bus1.if_rdata, e.data);
        end

        @(posedge clk);
        if (ig) begin
            q0.push_back('{due: cyc + 1, is_d: 1'b0, data: ref_mem[ia]});
            q1.push_back('{due: cyc + 2, is_d: 1'b0, data: ref_mem[ia]});
            ec_read = 1'b1; ec_write = 1'b0; ec_addr = ia; ec_f3 = 3'b010;
        end else if (dg) begin
            ec_addr = da;
            ec_f3   = df;
            if (dw) begin
                ref_mem[da] = dwd;
                ec_wdata = dwd; ec_read = 1'b0; ec_write = 1'b1;
            end else begin
                q0.push_back('{due: cyc + 1, is_d: 1'b1, data: ref_mem[da]});
                q1.push_back('{due: cyc + 2, is_d: 1'b1, data: ref_mem[da]});
                ec_read = 1'b1; ec_write = 1'b0;
            end
        end else begin
            ec_read = 1'b0; ec_write = 1'b0;
        end
        wait_n = (ir && !ig) ? wait_n + 1 : 0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic ig, dg;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, ig, dg);
    endtask

    initial begin
        logic        ig, dg;
        logic        pif, pd, pdw;
        logic [11:0] pia, pda;
        logic [31:0] pdwd;
        logic [2:0]  pdf;

        for (int i = 0; i < 4096; i++) begin
            mem0[i]    = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
            mem1[i]    = mem0[i];
            ref_mem[i] = mem0[i];
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        #2;
        do_reset();

        // Fetch-only stream.
        step(1'b1, 12'h000, 1'b0, 1'b0, '0, '0, '0, ig, dg);
        step(1'b1, 12'h004, 1'b0, 1'b0, '0, '0, '0, ig, dg);
        step(1'b1, 12'h008, 1'b0, 1'b0, '0, '0, '0, ig, dg);
        idle(3);

        // Contention: data wins, fetch follows once data drops.
        step(1'b1, 12'h00c, 1'b1, 1'b0, 12'h100, '0, 3'b010, ig, dg);
        step(1'b1, 12'h00c, 1'b0, 1'b0, '0, '0, '0, ig, dg);
        idle(3);

        // Starvation: both held high; fetch forced every fifth cycle.
        for (int i = 0; i < 12; i++) step(1'b1, 12'h010, 1'b1, 1'b0, 12'h040, '0, 3'b100, ig, dg);
        idle(3);

        // Store then load to the same address.
        step(1'b0, '0, 1'b1, 1'b1, 12'h200, 32'hDEADBEEF, 3'b010, ig, dg);
        step(1'b0, '0, 1'b1, 1'b0, 12'h200, '0, 3'b010, ig, dg);
        idle(3);

        // Reset in the middle of a load.
        step(1'b0, '0, 1'b1, 1'b0, 12'h300, '0, 3'b010, ig, dg);
        do_reset();
        idle(3);
        step(1'b1, 12'h020, 1'b1, 1'b0, 12'h024, '0, 3'b001, ig, dg);
        idle(3);

        // Randomized traffic; requesters hold requests until granted, fetch may withdraw.
        pif = 1'b0; pd = 1'b0; pia = '0; pda = '0; pdw = 1'b0; pdwd = '0; pdf = '0;
        for (int i = 0; i < 500; i++) begin
            if (!pif && $urandom_range(0, 2) != 0) begin
                pif = 1'b1;
                pia = 12'($urandom_range(0, 15) * 4);
            end else if (pif && $urandom_range(0, 9) == 0) begin
                pif = 1'b0;
            end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd   = 1'b1;
                pdw  = 1'($urandom_range(0, 1));
                pda  = 12'($urandom_range(0, 15) * 4);
                pdwd = $urandom;
                pdf  = 3'($urandom_range(0, 7));
            end
            step(pif, pia, pd, pdw, pda, pdwd, pdf, ig, dg);
            if (ig) pif = 1'b0;
            if (dg) pd = 1'b0;
        end
        idle(6);
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between two requesters:
  - the fetch stage (IF port);
  - the memory-access stage (D port: loads and stores).
- Registers one command per cycle onto the memory port and routes read data back to the requester that issued it.
- Replaces the alternating half-rate fetch/data time-slicing. Pipeline stall signals are derived from its grants.

Parameters:
ADDR_W, 12, memory byte-address width
DATA_W, 32, data width
MEM_LAT, 1, cycles from command cycle to mem_rdata valid (0 = combinational read, max 4)
STARVE_MAX, 4, consecutive denied IF-request cycles before IF is force-granted (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_f3  in  3  funct3 size/sign code
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid
d_rdata  out  DATA_W  load data
mem_addr  out  ADDR_W  registered memory address
mem_read  out  1  registered read strobe
mem_write  out  1  registered write strobe
mem_wdata  out  DATA_W  registered write data
mem_f3  out  3  registered funct3 (fetch commands drive 3'b010)
mem_rdata  in  DATA_W  memory read data
stall_if  out  1  if_req & ~if_gnt
stall_d  out  1  d_req & ~d_gnt
busy  out  1  any read in flight or command on the port

Behaviour:
- Reset (async, takes effect immediately):
  - all mem_* outputs, rvalids, tag pipeline, starvation counter = 0;
  - FSM = DPRI.
  - In-flight reads are dropped: no rvalid appears after reset, including reset in the middle of a read.
- Arbitration is combinational in cycle t. At most one grant per cycle; back-to-back grants every cycle are allowed.
- FSM states:
  - DPRI: d_req wins; otherwise if_req wins.
  - IFORCE: if_req wins even if d_req is high.
  - DPRI -> IFORCE when starve_cnt reaches STARVE_MAX-1 and IF is denied in that cycle.
  - IFORCE -> DPRI on the cycle if_gnt=1, or if if_req drops.
- starve_cnt (4-bit):
  - increments on if_req & ~if_gnt;
  - clears on if_gnt or ~if_req;
  - saturates, never wraps.
- On posedge after grant cycle t, the granted request is registered onto mem_*; the command is visible in cycle t+1.
  - Store: mem_write=1, mem_read=0.
  - Load or fetch: mem_read=1, mem_write=0.
  - No grant: both strobes = 0; mem_addr, mem_wdata, mem_f3 hold their previous values.
- Tag pipeline:
  - depth MEM_LAT+1, entry {valid, is_d}, shifts every cycle, pushed for each read command.
  - The head asserts if_rvalid or d_rvalid in cycle t+1+MEM_LAT; with default MEM_LAT=1, that is t+2.
  - if_rdata and d_rdata both = mem_rdata. Each is qualified only by its own rvalid.
- Ordering:
  - Commands issue strictly in grant order.
  - A store granted at t followed by a load to the same address granted at t+1 must return the new data (memory write-first order is preserved).
- Stores produce no rvalid. A store is complete once granted.
- Requesters hold address and data stable while req=1 and gnt=0. The arbiter samples only in the grant cycle.
- Simultaneous if_req and d_req in DPRI: d_gnt=1, if_gnt=0, stall_if=1.
- busy = mem_read | mem_write | any valid tag entry.

Test Plan:
- Reset, then IF-only stream: if_req=1 at addrs 0,4,8 in cycles 1-3 -> if_gnt=1 each cycle; if_rvalid in cycles 3,4,5 with data from addrs 0,4,8; d_gnt=0 throughout.
- Contention: if_req=1 and d_req=1 (load, addr 0x100) in cycle 5 -> d_gnt=1, stall_if=1, mem_read=1 with mem_addr=0x100 in cycle 6, d_rvalid in cycle 7, if_gnt=1 in cycle 6 if d_req has dropped.
- Starvation with STARVE_MAX=4: d_req and if_req held high continuously -> if_gnt=1 exactly in the 5th contended cycle, d_gnt=0 in that cycle, then the pattern repeats with period 5.
- Store then load to 0x200: store granted at t (wdata 0xDEADBEEF), load granted at t+1 -> mem_write=1 at t+1, d_rvalid at t+3 with d_rdata=0xDEADBEEF, no rvalid for the store.
- Reset mid-read: load granted at t, rst pulsed at t+1 -> d_rvalid never asserts; all outputs 0 during rst; FSM=DPRI afterwards.
- MEM_LAT=0 build: fetch granted at t -> if_rvalid at t+1 with a combinational mem_rdata match.
